// File: rtl/cache_switch_pkg.sv
// Shared types and defaults for the cache context-switch scheduler.
// Optional feature macro used by this slice: CACHE_SWITCH_STATS_EN.
package cache_switch_pkg;

   localparam int DEF_NUM_BANKS = 4;
   localparam int DEF_PID_W     = 8;
   localparam int DEF_BANK_W    = $clog2(DEF_NUM_BANKS);
   localparam int STAT_W        = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_FLUSH_WAIT,
      ST_COMMIT
   } state_t;

   // One bank-table entry; age 0 is the most recently used bank.
   typedef struct packed {
      logic                  valid;
      logic [DEF_PID_W-1:0]  pid;
      logic [DEF_BANK_W-1:0] age;
   } entry_t;

   // Saturating increment for the statistics counters.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/cache_switch_lru.sv
// Combinational LRU helper: age update towards a new MRU bank and victim
// selection (lowest invalid bank first, else the oldest bank).
module cache_switch_lru
   import cache_switch_pkg::*;
#(
   parameter  int NUM_BANKS = DEF_NUM_BANKS,
   localparam int BANK_W    = $clog2(NUM_BANKS)
) (
   input  logic [NUM_BANKS-1:0][BANK_W-1:0] age,
   input  logic [NUM_BANKS-1:0]             valid,
   input  logic [BANK_W-1:0]                mru_bank,
   output logic [NUM_BANKS-1:0][BANK_W-1:0] age_next,
   output logic [BANK_W-1:0]                victim,
   output logic                             victim_valid
);

   // Banks younger than the new MRU bank age by one; the MRU bank becomes 0.
   always_comb begin
      age_next = age;
      for (int i = 0; i < NUM_BANKS; i++) begin
         if (BANK_W'(i) == mru_bank)
            age_next[i] = '0;
         else if (age[i] < age[mru_bank])
            age_next[i] = age[i] + 1'b1;
      end
   end

   // Prefer a free bank so no write-back is needed; otherwise evict the LRU.
   always_comb begin
      logic found;
      found  = 1'b0;
      victim = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         if (!valid[i] && !found) begin
            victim = BANK_W'(i);
            found  = 1'b1;
         end
      end
      if (!found) begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            if (age[i] == BANK_W'(NUM_BANKS - 1))
               victim = BANK_W'(i);
         end
      end
      victim_valid = valid[victim];
   end

endmodule

// File: rtl/cache_switch_ctrl.sv
// Context-switch scheduler: maps process IDs to cache banks, stalls the CPU
// during a switch and sequences a flush of an evicted bank.
// Optional macro CACHE_SWITCH_STATS_EN adds hit/miss statistics ports.
//
// state         | meaning
// --------------+-------------------------------------------------
// ST_IDLE       | waiting for sw_req; latch pid on accept
// ST_LOOKUP     | parallel tag compare, pick target bank
// ST_FLUSH_WAIT | flush_req held until the cache reports flush_done
// ST_COMMIT     | write table, move active_bank, pulse sw_ack
module cache_switch_ctrl
   import cache_switch_pkg::*;
#(
   parameter  int NUM_BANKS = DEF_NUM_BANKS,
   parameter  int PID_W     = DEF_PID_W,
   localparam int BANK_W    = $clog2(NUM_BANKS)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              sw_req,
   input  logic [PID_W-1:0]  sw_pid,
   output logic              sw_ack,
   output logic              cpu_stall,
   output logic [BANK_W-1:0] active_bank,
   output logic              flush_req,
   output logic [BANK_W-1:0] flush_bank,
`ifdef CACHE_SWITCH_STATS_EN
   output logic [STAT_W-1:0] stat_hits,
   output logic [STAT_W-1:0] stat_misses,
`endif
   input  logic              flush_done
);

   state_t                          state_q, state_d;
   logic [PID_W-1:0]                pid_q;
   logic [BANK_W-1:0]               tgt_q;
   entry_t                          tbl_q [NUM_BANKS];

   logic [NUM_BANKS-1:0][BANK_W-1:0] age_vec, age_next;
   logic [NUM_BANKS-1:0]             valid_vec, hit_vec;
   logic                             hit_any;
   logic [BANK_W-1:0]                hit_idx, victim, lookup_tgt;
   logic                             victim_valid;

   // Flatten the table for the compare and LRU logic.
   always_comb begin
      hit_idx = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         age_vec[i]   = tbl_q[i].age;
         valid_vec[i] = tbl_q[i].valid;
         hit_vec[i]   = tbl_q[i].valid && (tbl_q[i].pid == pid_q);
         if (hit_vec[i])
            hit_idx = BANK_W'(i);
      end
      hit_any    = |hit_vec;
      lookup_tgt = hit_any ? hit_idx : victim;
   end

   // During LOOKUP the victim comes from current ages; during COMMIT the
   // age update is driven by the latched target.
   cache_switch_lru #(.NUM_BANKS(NUM_BANKS)) u_lru (
      .age          (age_vec),
      .valid        (valid_vec),
      .mru_bank     (tgt_q),
      .age_next     (age_next),
      .victim       (victim),
      .victim_valid (victim_valid)
   );

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:       if (sw_req) state_d = ST_LOOKUP;
         ST_LOOKUP:     state_d = (hit_any || !victim_valid) ? ST_COMMIT : ST_FLUSH_WAIT;
         ST_FLUSH_WAIT: if (flush_done) state_d = ST_COMMIT;
         ST_COMMIT:     state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Registered control outputs and request latch.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         pid_q       <= '0;
         tgt_q       <= '0;
         sw_ack      <= 1'b0;
         cpu_stall   <= 1'b0;
         flush_req   <= 1'b0;
         flush_bank  <= '0;
         active_bank <= '0;
      end else begin
         sw_ack <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (sw_req) begin
                  pid_q     <= sw_pid;
                  cpu_stall <= 1'b1;
               end
            end
            ST_LOOKUP: begin
               tgt_q <= lookup_tgt;
               if (!hit_any && victim_valid) begin
                  flush_req  <= 1'b1;
                  flush_bank <= lookup_tgt;
               end
            end
            ST_FLUSH_WAIT: begin
               if (flush_done)
                  flush_req <= 1'b0;
            end
            ST_COMMIT: begin
               active_bank <= tgt_q;
               sw_ack      <= 1'b1;
               cpu_stall   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Bank table: install the new PID and refresh ages on commit.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            tbl_q[i].valid <= 1'b0;
            tbl_q[i].pid   <= '0;
            tbl_q[i].age   <= BANK_W'(i);
         end
      end else if (state_q == ST_COMMIT) begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            tbl_q[i].age <= age_next[i];
            if (BANK_W'(i) == tgt_q) begin
               tbl_q[i].valid <= 1'b1;
               tbl_q[i].pid   <= pid_q;
            end
         end
      end
   end

`ifdef CACHE_SWITCH_STATS_EN
   logic hit_q;

   // Remember whether LOOKUP hit so COMMIT knows which counter to bump.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)                    hit_q <= 1'b0;
      else if (state_q == ST_LOOKUP) hit_q <= hit_any;
   end

   // Saturating hit/miss counters, one increment per commit.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         stat_hits   <= '0;
         stat_misses <= '0;
      end else if (state_q == ST_COMMIT) begin
         if (hit_q) stat_hits   <= sat_inc(stat_hits);
         else       stat_misses <= sat_inc(stat_misses);
      end
   end
`endif

endmodule

// File: tb/tb_cache_switch_ctrl.sv
// Directed bench for cache_switch_ctrl; stats checks only when
// CACHE_SWITCH_STATS_EN is defined.
module tb_cache_switch_ctrl;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       sw_req;
   logic [7:0] sw_pid;
   logic       sw_ack;
   logic       cpu_stall;
   logic [1:0] active_bank;
   logic       flush_req;
   logic [1:0] flush_bank;
   logic       flush_done;
`ifdef CACHE_SWITCH_STATS_EN
   logic [15:0] stat_hits, stat_misses;
`endif

   int n_cmp = 0;
   int n_err = 0;

   cache_switch_ctrl dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .sw_req      (sw_req),
      .sw_pid      (sw_pid),
      .sw_ack      (sw_ack),
      .cpu_stall   (cpu_stall),
      .active_bank (active_bank),
      .flush_req   (flush_req),
      .flush_bank  (flush_bank),
`ifdef CACHE_SWITCH_STATS_EN
      .stat_hits   (stat_hits),
      .stat_misses (stat_misses),
`endif
      .flush_done  (flush_done)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete switch; flush_done is raised flush_delay cycles after
   // flush_req is first seen. Latency counts edges from accept to ack.
   task automatic do_switch(input string tag, input logic [7:0] pid,
                            input logic [1:0] exp_bank, input bit exp_flush,
                            input logic [1:0] exp_fbank, input int flush_delay,
                            input bit corrupt_pid);
      int n, fcnt;
      bit got, saw;
      logic [1:0] fb;
      @(negedge CLK);
      sw_req = 1'b1;
      sw_pid = pid;
      @(posedge CLK); #1;
      check({tag, " stall_on"}, cpu_stall, 1);
      if (corrupt_pid) sw_pid = 8'hEE;
      n = 0; fcnt = 0; got = 0; saw = 0; fb = '0;
      while (!got && n < 60) begin
         @(posedge CLK); #1;
         n++;
         if (flush_req) begin
            saw = 1;
            fb  = flush_bank;
            fcnt++;
            flush_done = (fcnt == flush_delay);
         end else begin
            flush_done = 1'b0;
         end
         if (sw_ack) got = 1;
      end
      sw_req     = 1'b0;
      flush_done = 1'b0;
      check({tag, " ack_seen"}, got, 1);
      check({tag, " latency"}, n + 1, exp_flush ? flush_delay + 3 : 3);
      check({tag, " active_bank"}, active_bank, exp_bank);
      check({tag, " stall_off"}, cpu_stall, 0);
      check({tag, " flush_seen"}, saw, exp_flush);
      if (exp_flush) check({tag, " flush_bank"}, fb, exp_fbank);
      @(posedge CLK); #1;
      check({tag, " ack_pulse"}, sw_ack, 0);
      check({tag, " idle_stall"}, cpu_stall, 0);
   endtask

   initial begin
      int n;
      RESET = 1'b0; sw_req = 1'b0; sw_pid = '0; flush_done = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst sw_ack", sw_ack, 0);
      check("rst cpu_stall", cpu_stall, 0);
      check("rst active_bank", active_bank, 0);
      check("rst flush_req", flush_req, 0);
      check("rst flush_bank", flush_bank, 0);
`ifdef CACHE_SWITCH_STATS_EN
      check("rst stat_hits", stat_hits, 0);
      check("rst stat_misses", stat_misses, 0);
`endif
      @(negedge CLK); RESET = 1'b1;

      do_switch("p05", 8'h05, 2'd0, 0, 2'd0, 0, 0);

      @(negedge CLK); RESET = 1'b0;
      #2 RESET = 1'b1;

      // Ages after fill: bank0..3 = 3,2,1,0; after hit on pid 2: 3,0,2,1.
      do_switch("p01", 8'h01, 2'd0, 0, 2'd0, 0, 0);
      do_switch("p02", 8'h02, 2'd1, 0, 2'd0, 0, 0);
      do_switch("p03", 8'h03, 2'd2, 0, 2'd0, 0, 0);
      do_switch("p04", 8'h04, 2'd3, 0, 2'd0, 0, 0);
      do_switch("hit2", 8'h02, 2'd1, 0, 2'd0, 0, 1);
      do_switch("p09", 8'h09, 2'd0, 1, 2'd0, 10, 0);
`ifdef CACHE_SWITCH_STATS_EN
      check("stat_hits seq", stat_hits, 1);
      check("stat_misses seq", stat_misses, 5);
`endif

      // Stray flush_done in IDLE must have no effect.
      @(negedge CLK); flush_done = 1'b1;
      @(posedge CLK); #1;
      check("idle_fd sw_ack", sw_ack, 0);
      check("idle_fd stall", cpu_stall, 0);
      check("idle_fd flush_req", flush_req, 0);
      check("idle_fd active_bank", active_bank, 0);
      @(negedge CLK); flush_done = 1'b0;

      // Ages now 0,1,3,2: pid 4 in bank 3 hits; ages become 1,2,3,0.
      do_switch("hit4", 8'h04, 2'd3, 0, 2'd0, 0, 0);
`ifdef CACHE_SWITCH_STATS_EN
      check("stat_hits hit4", stat_hits, 2);
`endif

      // Miss on pid 7 evicts bank 2 (age 3); reset while waiting on flush.
      @(negedge CLK); sw_req = 1'b1; sw_pid = 8'h07;
      n = 0;
      while (!flush_req && n < 10) begin
         @(posedge CLK); #1;
         n++;
      end
      sw_req = 1'b0;
      check("mid flush_req up", flush_req, 1);
      check("mid flush_bank", flush_bank, 2);
      repeat (2) @(posedge CLK);
      #3 RESET = 1'b0;
      #1;
      check("mid rst flush_req", flush_req, 0);
      check("mid rst stall", cpu_stall, 0);
      check("mid rst active_bank", active_bank, 0);
      check("mid rst sw_ack", sw_ack, 0);
`ifdef CACHE_SWITCH_STATS_EN
      check("mid rst stat_hits", stat_hits, 0);
`endif
      @(negedge CLK); RESET = 1'b1;

      // Table cleared: pid 4 misses into free bank 0.
      do_switch("p04 after rst", 8'h04, 2'd0, 0, 2'd0, 0, 0);
`ifdef CACHE_SWITCH_STATS_EN
      check("stat_misses after rst", stat_misses, 1);
      check("stat_hits after rst", stat_hits, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cache_switch_ctrl.md
# cache_switch_ctrl

Context-switch scheduler for the OS-initiated cache switching scheme. It owns a process-ID-to-cache-bank table and decides which physical cache bank the CPU uses. It stalls the CPU while a switch is in progress and sequences a write-back flush of an evicted bank before reassigning it. It sits between the CSR write path, which issues switch requests, and the banked data cache.

## Interface
- NUM_BANKS, 4: number of physical cache banks; power of two, at least 2
- PID_W, 8: process-ID width
- BANK_W, $clog2(NUM_BANKS): bank index width (derived)

- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  asynchronous, active-low reset (RESET=0 resets)
- sw_req  in  1  switch request; a level held by the requester until sw_ack
- sw_pid  in  PID_W  target process ID; stable while sw_req is high
- sw_ack  out  1  one-cycle registered pulse; the switch is committed
- cpu_stall  out  1  freezes the CPU pipeline while a switch is in flight
- active_bank  out  BANK_W  bank currently used by the CPU
- flush_req  out  1  write back and invalidate bank flush_bank; held until done
- flush_bank  out  BANK_W  bank to flush; stable while flush_req is high
- flush_done  in  1  flush complete; sampled only in FLUSH_WAIT
- stat_hits, stat_misses  out  16 each  switch statistics (only with the macro)

## Operation
- Table has one entry per bank: valid, pid, age (BANK_W bits). Ages always form a permutation of 0..NUM_BANKS-1; 0 means most recently used.
- Reset values:
  - all valid=0; age[i]=i
  - active_bank=0, sw_ack=0, cpu_stall=0, flush_req=0, flush_bank=0, stats=0
  - state IDLE
- FSM states: IDLE, LOOKUP, FLUSH_WAIT, COMMIT.
- IDLE: if sw_req=1, latch sw_pid into pid_q, set cpu_stall=1, go to LOOKUP.
- LOOKUP: compare pid_q against all valid entries in parallel.
  - Hit (including the current bank's PID): tgt=matching bank, go to COMMIT.
  - Miss: tgt=lowest-index invalid bank if one exists, else the bank with age NUM_BANKS-1.
  - Miss with an invalid tgt: go straight to COMMIT.
  - Miss with a valid tgt: set flush_req=1 and flush_bank=tgt, go to FLUSH_WAIT.
- FLUSH_WAIT: hold flush_req. When flush_done=1, clear flush_req and go to COMMIT. There is no timeout.
- COMMIT, all in one edge:
  - entry[tgt] gets valid=1, pid=pid_q
  - active_bank=tgt
  - age update: every bank whose age is below old age[tgt] increments; age[tgt]=0
  - sw_ack=1 for one cycle, cpu_stall=0, return to IDLE
- The requester must drop sw_req in the cycle sw_ack is high. If sw_req is still high in the following IDLE cycle, it is a new request.
- flush_done outside FLUSH_WAIT is ignored.
- sw_req changes while the block is busy are ignored; pid_q is already latched.
- RESET asserted mid-operation: all outputs return to reset values immediately (asynchronously), including dropping flush_req. The table is cleared. A flush already in progress in the cache is abandoned by the cache's own reset.

## Timing
- Edge 0 is the edge that samples sw_req=1 in IDLE. cpu_stall is high from just after edge 0.
- Hit or invalid-victim path: LOOKUP at edge 1, COMMIT at edge 2. sw_ack is high in the cycle after edge 2, when cpu_stall is already 0 and active_bank already holds the new value. Latency is 3 cycles.
- Flush path: flush_req rises after edge 1. With flush_done sampled high at edge k, COMMIT happens at edge k+1 and sw_ack is high in the cycle after it.
- flush_req and flush_bank are registered with no combinational path to flush_done.

## Configuration
- CACHE_SWITCH_STATS_EN defined: the block has the stat_hits and stat_misses ports.
  - Each COMMIT increments one counter: stat_hits if LOOKUP hit, stat_misses otherwise.
  - Counters saturate at 16'hFFFF and reset to 0.
- CACHE_SWITCH_STATS_EN undefined: these ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package cache_switch_pkg holds:
  - the FSM state enum
  - a table-entry typedef {valid, pid, age}
  - default NUM_BANKS and PID_W constants
- One sub-module, cache_switch_lru: a combinational age-update and victim select over the age vector. It is unit-testable on its own.

## Test plan
- Reset, then a switch to pid 8'h05: victim is bank 0 (invalid, no flush). sw_ack occurs 3 cycles after the accept edge; active_bank=0; flush_req never rises.
- Fill pids 1,2,3,4 into banks 0..3, then switch to pid 2: hit, active_bank=1, no flush, latency 3 cycles.
- After the sequence 1,2,3,4,2, switch to pid 9: victim is bank 0 (LRU). flush_req=1 with flush_bank=0; flush_done arrives after 10 cycles; then ack and active_bank=0.
- Pulse flush_done while in IDLE, then request a hit: no state change and no extra ack.
- Drive RESET low during FLUSH_WAIT: flush_req and cpu_stall drop asynchronously. A subsequent switch to the previously resident pid misses.
- With CACHE_SWITCH_STATS_EN, the sequence above gives stat_hits=1 and stat_misses=5.
